mux4x1_arbiter: RTL

- Round-robin arbiter and sequencer for the 4-to-1 `mux4x1` lane selector.
- Four requesters each own one 2-bit mux input lane. The block drives the mux `sel` and a one-hot grant, and presents a valid/ready handshake on the muxed output.
- A grant is held for a burst of up to `MAX_BEATS` transfers, then forcibly rotated.
- Sits directly in front of `mux4x1`: `sel` connects to the mux select, `out_valid`/`out_ready` accompany mux output `y`.

---
 rtl/mux4x1_arbiter_if.sv | 31 +++
 rtl/mux4x1_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mux4x1_arbiter_if.sv
// Request/grant and muxed-output handshake bundle between mux4x1_arbiter and its lanes.
// The master side is the arbiter; the slave side is the requesters plus downstream.
interface mux4x1_arbiter_if;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] beat_ack;
    logic       busy;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output gnt,
        output out_valid,
        output beat_ack,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  gnt,
        input  out_valid,
        input  beat_ack,
        input  busy
    );
endinterface

// File: rtl/mux4x1_arbiter.sv
// Round-robin arbiter/sequencer for a 4-to-1 lane mux: bursts of up to MAX_BEATS
// transfers per grant, zero-bubble handover, last grantee at lowest priority.
module mux4x1_arbiter #(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4x1_arbiter_if.master bus
);
    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   last;
    logic [CNT_W-1:0]   beat_cnt;
    logic [SEL_W-1:0]   sel_q;
    logic [LANES-1:0]   gnt_q;
    logic               busy_q;

    logic               valid;
    logic               xfer;
    logic               rel;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;

    // Search starts one past the last grantee, so it always ends up lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && bus.req[last + SEL_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = last + SEL_W'(k);
            end
        end
    end

    always_comb begin
        valid = (state == GRANT) && bus.req[sel_q];
        xfer  = valid && bus.out_ready;
        rel   = (state == GRANT) &&
                (!bus.req[sel_q] || (xfer && (beat_cnt == CNT_W'(MAX_BEATS - 1))));
    end

    // gnt_q is one-hot on sel_q, so masking it yields the per-lane acknowledge.
    assign bus.beat_ack  = gnt_q & {LANES{xfer && rst_n}};
    assign bus.out_valid = valid;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= SEL_W'(3);
            beat_cnt <= '0;
            sel_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= GRANT;
                        sel_q    <= win_idx;
                        gnt_q    <= LANES'(1) << win_idx;
                        last     <= win_idx;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                    end else begin
                        sel_q  <= '0;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        // Hand over directly to the next winner; fall back to IDLE only if nobody asks.
                        if (win_found) begin
                            sel_q    <= win_idx;
                            gnt_q    <= LANES'(1) << win_idx;
                            last     <= win_idx;
                            beat_cnt <= '0;
                            busy_q   <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            sel_q    <= '0;
                            gnt_q    <= '0;
                            beat_cnt <= '0;
                            busy_q   <= 1'b0;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    sel_q  <= '0;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
